// File: rtl/mem_access_sequencer.sv
// Purpose : MEM-stage sequencer; turns a load/store enable into one registered memory request and waits for ack or timeout.
// Latency : request seen in IDLE at cycle N, ack at N+1+k -> done at N+2+k (minimum two stall cycles).
// Backpres: stall holds the upstream pipeline from request acceptance until the access leaves ACCESS; no stall in DONE.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   mem_read_enable          MEM-stage instruction is a load
//   mem_write_enable         MEM-stage instruction is a store (wins if both are set)
//   alu_result, write_data   effective address and store data, latched on acceptance
//   mem_ack, mem_rdata       memory completion and load data, honoured only in ACCESS
//   mem_req, mem_we          registered request and direction (1 = write)
//   mem_addr, mem_wdata      registered address and store data, stable for the whole access
//   stall                    combinational pipeline freeze
//   done                     one-cycle completion pulse
//   read_data_out            registered load result (0 after a timed-out load)
//   err                      sticky timeout flag, cleared only by rst
module mem_access_sequencer #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] read_data_out,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Last ACCESS cycle index: reaching it with no ack aborts the access.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  // Everything that must stay frozen while the memory works on the access.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_req_t;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  acc_req_t         req_q;
  logic             any_en;

  assign any_en    = mem_read_enable | mem_write_enable;

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // Reset overrides the freeze so the pipeline is never held by a block
  // that is being cleared.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = ((state == ST_IDLE) && any_en) || (state == ST_ACCESS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      req_q         <= '0;
      mem_req       <= 1'b0;
      done          <= 1'b0;
      read_data_out <= '0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_en) begin
            // A store wins when both enables are set.
            req_q.we    <= mem_write_enable;
            req_q.addr  <= alu_result;
            req_q.wdata <= write_data;
            mem_req     <= 1'b1;
            cnt         <= '0;
            state       <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (mem_ack) begin
            // Ack is checked first so it beats a timeout on the same cycle.
            mem_req <= 1'b0;
            if (!req_q.we) begin
              read_data_out <= mem_rdata;
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            if (!req_q.we) begin
              read_data_out <= '0;
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // Enables are deliberately ignored here; a held request is
          // picked up on the following IDLE cycle.
          state <= ST_IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic          wr_en;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] write_data;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          stall;
  logic          done;
  logic [DW-1:0] read_data_out;
  logic          err;

  mem_access_sequencer #(.DATA_W(DW), .TIMEOUT(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read_enable  (rd_en),
    .mem_write_enable (wr_en),
    .alu_result       (alu_result),
    .write_data       (write_data),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .stall            (stall),
    .done             (done),
    .read_data_out    (read_data_out),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_exp_t;

  typedef struct packed {
    logic [DW-1:0] rdo;
    logic          err;
  } cmp_exp_t;

  req_exp_t req_q[$];
  cmp_exp_t cmp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_rdo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_req(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
    req_exp_t e;
    e.we = we;
    e.addr = addr;
    e.wdata = wdata;
    req_q.push_back(e);
  endtask

  task automatic exp_cmp(input logic [DW-1:0] rdo, input logic e_err);
    cmp_exp_t e;
    e.rdo = rdo;
    e.err = e_err;
    cmp_q.push_back(e);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: compares every new memory request and every done pulse against the queues.
  logic req_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !req_prev) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 64'(1), 64'(0));
        end else begin
          req_exp_t e;
          e = req_q.pop_front();
          check("req_we", 64'(mem_we), 64'(e.we));
          check("req_addr", 64'(mem_addr), 64'(e.addr));
          check("req_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end
      req_prev = mem_req;
      if (done) begin
        if (cmp_q.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          cmp_exp_t c;
          c = cmp_q.pop_front();
          check("done_rdata", 64'(read_data_out), 64'(c.rdo));
          check("done_err", 64'(err), 64'(c.err));
        end
      end
    end
  end

  // Read with ack on the first ACCESS cycle.
  task automatic quick_read(input logic [DW-1:0] addr, input logic [DW-1:0] data, input logic e_err);
    rd_en = 1'b1; alu_result = addr; write_data = '0;
    exp_req(1'b0, addr, '0);
    exp_cmp(data, e_err);
    exp_rdo = data;
    at_neg(); nxt();
    rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = data;
    at_neg(); nxt();
    mem_ack = 1'b0;
    at_neg();
    check("qr_done", 64'(done), 64'(1));
    nxt();
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_ack = 1'b0;
    alu_result = '0; write_data = '0; mem_rdata = '0;
    nxt();
    rd_en = 1'b1;
    at_neg();
    check("stall_in_reset", 64'(stall), 64'(0));
    nxt();
    rd_en = 1'b0; rst = 1'b0;
    at_neg();
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rdo", 64'(read_data_out), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    nxt();

    // Ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = 24'h999999;
    at_neg(); nxt();
    mem_ack = 1'b0;
    at_neg();
    check("idle_ack_done", 64'(done), 64'(0));
    check("idle_ack_rdo", 64'(read_data_out), 64'(0));
    nxt();

    // Load with immediate ack.
    rd_en = 1'b1; alu_result = 24'h000010; write_data = '0;
    exp_req(1'b0, 24'h000010, '0);
    exp_cmp(24'hABCDEF, 1'b0);
    exp_rdo = 24'hABCDEF;
    at_neg();
    check("ld_stall_c0", 64'(stall), 64'(1));
    nxt();
    rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = 24'hABCDEF;
    at_neg();
    check("ld_stall_c1", 64'(stall), 64'(1));
    check("ld_addr_c1", 64'(mem_addr), 64'h10);
    check("ld_we_c1", 64'(mem_we), 64'(0));
    nxt();
    mem_ack = 1'b0;
    at_neg();
    check("ld_done_c2", 64'(done), 64'(1));
    check("ld_stall_c2", 64'(stall), 64'(0));
    nxt();
    at_neg();
    check("ld_done_c3", 64'(done), 64'(0));
    nxt();

    // Store with three wait cycles; inputs change afterwards to prove the hold.
    wr_en = 1'b1; alu_result = 24'h000020; write_data = 24'h123456;
    exp_req(1'b1, 24'h000020, 24'h123456);
    exp_cmp(exp_rdo, 1'b0);
    at_neg(); nxt();
    wr_en = 1'b0; alu_result = 24'hFFFFFF; write_data = '0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        mem_ack = 1'b1; mem_rdata = 24'h010101;
      end
      at_neg();
      check("st_hold_req", 64'(mem_req), 64'(1));
      check("st_hold_we", 64'(mem_we), 64'(1));
      check("st_hold_wdata", 64'(mem_wdata), 64'h123456);
      check("st_hold_addr", 64'(mem_addr), 64'h20);
      nxt();
    end
    mem_ack = 1'b0;
    at_neg();
    check("st_done_c5", 64'(done), 64'(1));
    nxt();

    // Timeout: read never acked.
    rd_en = 1'b1; alu_result = 24'h000030; write_data = '0;
    exp_req(1'b0, 24'h000030, '0);
    exp_cmp('0, 1'b1);
    exp_rdo = '0;
    at_neg(); nxt();
    rd_en = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      at_neg();
      check("to_stall", 64'(stall), 64'(1));
      check("to_no_err", 64'(err), 64'(0));
      nxt();
    end
    at_neg();
    check("to_done_c16", 64'(done), 64'(1));
    check("to_err_c16", 64'(err), 64'(1));
    check("to_rdo_c16", 64'(read_data_out), 64'(0));
    nxt();
    quick_read(24'h000031, 24'h555555, 1'b1);
    at_neg();
    check("err_sticky", 64'(err), 64'(1));
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    exp_rdo = '0;
    at_neg();
    check("err_cleared", 64'(err), 64'(0));
    nxt();

    // Ack collides with the timeout cycle.
    rd_en = 1'b1; alu_result = 24'h000040;
    exp_req(1'b0, 24'h000040, '0);
    exp_cmp(24'h0F0F0F, 1'b0);
    exp_rdo = 24'h0F0F0F;
    at_neg(); nxt();
    rd_en = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) begin
        mem_ack = 1'b1; mem_rdata = 24'h0F0F0F;
      end
      at_neg(); nxt();
    end
    mem_ack = 1'b0;
    at_neg();
    check("col_done", 64'(done), 64'(1));
    check("col_err", 64'(err), 64'(0));
    check("col_rdo", 64'(read_data_out), 64'h0F0F0F);
    nxt();

    // Reset in the middle of a pending read.
    rd_en = 1'b1; alu_result = 24'h000050;
    exp_req(1'b0, 24'h000050, '0);
    at_neg(); nxt();
    rd_en = 1'b0;
    at_neg();
    check("mid_req_c1", 64'(mem_req), 64'(1));
    nxt();
    rst = 1'b1;
    at_neg();
    check("mid_stall_rst", 64'(stall), 64'(0));
    nxt();
    rst = 1'b0;
    exp_rdo = '0;
    at_neg();
    check("mid_req_c3", 64'(mem_req), 64'(0));
    check("mid_done_c3", 64'(done), 64'(0));
    check("mid_stall_c3", 64'(stall), 64'(0));
    nxt();
    quick_read(24'h000051, 24'h777777, 1'b0);

    // Both enables, then a request held through DONE.
    rd_en = 1'b1; wr_en = 1'b1; alu_result = 24'h000060; write_data = 24'hAAAAAA;
    exp_req(1'b1, 24'h000060, 24'hAAAAAA);
    exp_cmp(exp_rdo, 1'b0);
    at_neg();
    check("both_stall", 64'(stall), 64'(1));
    nxt();
    rd_en = 1'b0; wr_en = 1'b0; write_data = '0;
    mem_ack = 1'b1; mem_rdata = 24'h111111;
    at_neg();
    check("both_we", 64'(mem_we), 64'(1));
    nxt();
    mem_ack = 1'b0; rd_en = 1'b1; alu_result = 24'h000070;
    exp_req(1'b0, 24'h000070, '0);
    exp_cmp(24'h3C3C3C, 1'b0);
    exp_rdo = 24'h3C3C3C;
    at_neg();
    check("b2b_done_c2", 64'(done), 64'(1));
    check("b2b_stall_c2", 64'(stall), 64'(0));
    nxt();
    at_neg();
    check("b2b_stall_c3", 64'(stall), 64'(1));
    check("b2b_req_c3", 64'(mem_req), 64'(0));
    nxt();
    rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = 24'h3C3C3C;
    at_neg();
    check("b2b_req_c4", 64'(mem_req), 64'(1));
    check("b2b_addr_c4", 64'(mem_addr), 64'h70);
    nxt();
    mem_ack = 1'b0;
    at_neg();
    check("b2b_done_c5", 64'(done), 64'(1));
    nxt();

    repeat (3) nxt();
    at_neg();
    check("req_queue_empty", 64'(req_q.size()), 64'(0));
    check("cmp_queue_empty", 64'(cmp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
